// File: rtl/conv_channel_accum.sv
// conv_channel_accum: sums CHANNEL_NUM_IN consecutive partial maps from the conv core into one map.
// Optional build macro CONV_CHANNEL_ACCUM_SATURATE_EN turns every add into a signed saturating add.
module conv_channel_accum #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMAGE_WIDTH    = 16,
  parameter int IMAGE_HEIGHT   = 16,
  parameter int IMAGE_SIZE     = 256,
  parameter int CHANNEL_NUM_IN = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int CNT_CH_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam logic [ADDR_WIDTH-1:0]   LAST_PIX = ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_CH_WIDTH-1:0] LAST_CH  = CNT_CH_WIDTH'(CHANNEL_NUM_IN - 1);

  logic [ADDR_WIDTH-1:0]   pix_cnt;
  logic [CNT_CH_WIDTH-1:0] ch_cnt;
  logic [DATA_WIDTH-1:0]   acc [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0]   acc_rd;
  logic [DATA_WIDTH-1:0]   acc_sum;
  logic [DATA_WIDTH-1:0]   final_sum;
  logic                    first_ch;
  logic                    last_ch;
  logic                    acc_we;

  function automatic logic [DATA_WIDTH-1:0] add_px(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] s;
`ifdef CONV_CHANNEL_ACCUM_SATURATE_EN
    s = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
      s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    s = a + b;
`endif
    return s;
  endfunction

  assign acc_rd    = acc[pix_cnt];
  assign first_ch  = (ch_cnt == '0);
  assign last_ch   = (ch_cnt == LAST_CH);
  assign acc_sum   = add_px(acc_rd, pxl_in);
  assign final_sum = (CHANNEL_NUM_IN == 1) ? pxl_in : acc_sum;
  // The last channel feeds the output directly, so its sum never needs storing.
  assign acc_we    = valid_in && !reset && !last_ch;

  // NOTE: the accumulator RAM has no reset; channel 0 always overwrites, so stale data never leaks.
  always_ff @(posedge clk) begin
    if (acc_we)
      acc[pix_cnt] <= first_ch ? pxl_in : acc_sum;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt   <= '0;
      ch_cnt    <= '0;
      pxl_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (last_ch) begin
          pxl_out   <= final_sum;
          valid_out <= 1'b1;
        end
        if (pix_cnt == LAST_PIX) begin
          pix_cnt <= '0;
          ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_channel_accum.sv
// Directed bench for conv_channel_accum: three configurations share one clock and reset,
// expected sums go into a scoreboard queue at drive time and are popped when valid_out fires.
module tb_conv_channel_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_vin, b_vin, c_vin;
  logic [31:0] a_din, c_din;
  logic [7:0]  b_din;
  logic [31:0] a_pout, c_pout;
  logic [7:0]  b_pout;
  logic        a_vout, b_vout, c_vout;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  int          hold [3];

`ifdef CONV_CHANNEL_ACCUM_SATURATE_EN
  localparam int POS_EXP = 127;
  localparam int NEG_EXP = -128;
`else
  localparam int POS_EXP = -56;
  localparam int NEG_EXP = 56;
`endif

  always #5 clk = ~clk;

  // unit 0: 2x2 map, 3 channels, 32-bit
  conv_channel_accum #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .IMAGE_SIZE(4),
    .CHANNEL_NUM_IN(3), .ADDR_WIDTH(2), .CNT_CH_WIDTH(2)
  ) dut_a (
    .clk(clk), .reset(reset), .valid_in(a_vin), .pxl_in(a_din),
    .pxl_out(a_pout), .valid_out(a_vout)
  );

  // unit 1: 2x1 map, 2 channels, 8-bit (overflow behaviour)
  conv_channel_accum #(
    .DATA_WIDTH(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(1), .IMAGE_SIZE(2),
    .CHANNEL_NUM_IN(2), .ADDR_WIDTH(1), .CNT_CH_WIDTH(1)
  ) dut_b (
    .clk(clk), .reset(reset), .valid_in(b_vin), .pxl_in(b_din),
    .pxl_out(b_pout), .valid_out(b_vout)
  );

  // unit 2: 2x2 map, single channel pass-through
  conv_channel_accum #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .IMAGE_SIZE(4),
    .CHANNEL_NUM_IN(1), .ADDR_WIDTH(2), .CNT_CH_WIDTH(1)
  ) dut_c (
    .clk(clk), .reset(reset), .valid_in(c_vin), .pxl_in(c_din),
    .pxl_out(c_pout), .valid_out(c_vout)
  );

  task automatic observe(input int unit, output logic v, output logic [31:0] p);
    case (unit)
      0:       begin v = a_vout; p = a_pout; end
      1:       begin v = b_vout; p = {{24{b_pout[7]}}, b_pout}; end
      default: begin v = c_vout; p = c_pout; end
    endcase
  endtask

  // One clock of stimulus on one unit, then check valid_out and pxl_out one cycle later.
  task automatic step(input int unit, input logic v, input int d, input logic last, input int exp);
    logic        ov;
    logic [31:0] op;
    a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
    case (unit)
      0:       begin a_vin = v; a_din = 32'(d); end
      1:       begin b_vin = v; b_din = 8'(d); end
      default: begin c_vin = v; c_din = 32'(d); end
    endcase
    if (v && last) sb.push_back(32'(exp));
    @(posedge clk);
    #1;
    observe(unit, ov, op);
    checks++;
    assert (ov === (v && last)) else begin
      failures++;
      $error("FAIL u%0d_valid observed=%0b expected=%0b", unit, ov, v && last);
    end
    if (ov === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL u%0d_spurious observed=1 expected=0 (scoreboard empty)", unit);
      end
      if (sb.size() > 0) hold[unit] = int'(sb.pop_front());
    end
    checks++;
    assert (op === 32'(hold[unit])) else begin
      failures++;
      $error("FAIL u%0d_pxl observed=%0d expected=%0d", unit, $signed(op), hold[unit]);
    end
  endtask

  // Reset with unit 0 presenting a pixel (reset must win), then one idle cycle.
  task automatic do_reset(input int cycles);
    logic        ov;
    logic [31:0] op;
    reset = 1'b1;
    a_vin = 1'b1; a_din = 32'd999; b_vin = 1'b0; c_vin = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) hold[i] = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
        observe(u, ov, op);
        checks++;
        assert (ov === 1'b0 && op === 32'd0) else begin
          failures++;
          $error("FAIL rst_u%0d observed=%0b/%0d expected=0/0", u, ov, $signed(op));
        end
      end
    end
    reset = 1'b0;
    step(0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic map_a(input int c0 [4], input int c1 [4], input int c2 [4], input int max_gap);
    for (int ch = 0; ch < 3; ch++) begin
      for (int p = 0; p < 4; p++) begin
        int d;
        d = (ch == 0) ? c0[p] : (ch == 1) ? c1[p] : c2[p];
        if (max_gap > 0) repeat ($urandom_range(max_gap, 1)) step(0, 1'b0, 0, 1'b0, 0);
        step(0, 1'b1, d, ch == 2, c0[p] + c1[p] + c2[p]);
      end
    end
  endtask

  initial begin
    int c0 [4];
    int c1 [4];
    int c2 [4];
    int m1 [4];
    int f5 [4];
    int seq_c [4];

    reset = 1'b1;
    a_vin = 1'b0; b_vin = 1'b0; c_vin = 1'b0;
    a_din = '0; b_din = '0; c_din = '0;
    c0 = '{1, 2, 3, 4};
    c1 = '{10, 20, 30, 40};
    c2 = '{100, 200, 300, 400};
    m1 = '{-1, -1, -1, -1};
    f5 = '{5, 5, 5, 5};
    seq_c = '{7, -7, 0, 9};

    do_reset(3);

    // contiguous map, then gapped map, then an all -1 map with no idle gap in between
    map_a(c0, c1, c2, 0);
    map_a(c0, c1, c2, 2);
    map_a(m1, m1, m1, 0);

    // 8-bit overflow: wrap or saturate, then a clean map to show no residue
    step(1, 1'b1, 100, 1'b0, 0);
    step(1, 1'b1, -100, 1'b0, 0);
    step(1, 1'b1, 100, 1'b1, POS_EXP);
    step(1, 1'b1, -100, 1'b1, NEG_EXP);
    step(1, 1'b1, 5, 1'b0, 0);
    step(1, 1'b1, -3, 1'b0, 0);
    step(1, 1'b0, 0, 1'b0, 0);
    step(1, 1'b1, 2, 1'b1, 7);
    step(1, 1'b1, -4, 1'b1, -7);

    // single channel: each input appears one cycle later, with and without gaps
    for (int p = 0; p < 4; p++) step(2, 1'b1, seq_c[p], 1'b1, seq_c[p]);
    step(2, 1'b0, 0, 1'b0, 0);
    step(2, 1'b1, -123456, 1'b1, -123456);

    // mid-map reset after channel 1 pixel 1 discards the partial sums
    for (int p = 0; p < 4; p++) step(0, 1'b1, c0[p], 1'b0, 0);
    step(0, 1'b1, 10, 1'b0, 0);
    step(0, 1'b1, 20, 1'b0, 0);
    do_reset(2);
    map_a(f5, f5, f5, 0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0 pending results", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
